mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one word-addressed external memory port between the processor's instruction-fetch interface (InstMem_*) and data interface (DataMem_*).
- Sits between the Processor core and the single-ported system memory/bus.
- Serializes requests with fair alternation, holds request fields stable for the memory, and returns single-cycle acks to the winning requester.
- Includes a no-ack watchdog so a dead slave cannot hang the core.

Parameters:
- ADDR_W, 30, word-address width.
- TIMEOUT, 255, max cycles waiting for Mem_Ack before bus-error completion; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- InstMem_Address  in  ADDR_W  fetch word address.
- InstMem_Read  in  1  fetch request; held until InstMem_Ack.
- InstMem_In  out  32  fetch data; valid when InstMem_Ack=1.
- InstMem_Ack  out  1  one-cycle fetch completion pulse.
- DataMem_Address  in  ADDR_W  data word address.
- DataMem_Read  in  1  load request.
- DataMem_Write  in  4  store byte enables; nonzero = store request.
- DataMem_Out  in  32  store data from core.
- DataMem_In  out  32  load data; valid when DataMem_Ack=1.
- DataMem_Ack  out  1  one-cycle data completion pulse.
- Mem_Address  out  ADDR_W  memory address.
- Mem_Read  out  1  memory read strobe.
- Mem_Write  out  4  memory byte write enables.
- Mem_WriteData  out  32  memory write data.
- Mem_ReadData  in  32  memory read data; valid with Mem_Ack.
- Mem_Ack  in  1  memory completion.
- Bus_Error  out  1  one-cycle pulse on a timeout completion.

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant=INST, so data wins the first tie; watchdog counter cleared. Reset mid-transaction abandons it with no ack.
- Requests: I_req = InstMem_Read. D_req = DataMem_Read | (DataMem_Write != 0). If a write is requested, DataMem_Read is ignored (store wins).
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - only one request pending -> grant it.
  - both pending -> grant the requester opposite last_grant.
  - on grant, at the next edge: register address (and for data, write enables and data), enter BUSY_x, update last_grant.
- BUSY_x:
  - Drive Mem_Read, or Mem_Write with Mem_WriteData, from the registers; all are stable for the whole state.
  - Core inputs are not re-sampled while in this state.
- Mem_Ack in BUSY_x:
  - Next edge: drop Mem_Read/Mem_Write to 0 and enter RESP.
  - Pulse the matching *_Ack. For a read, load the matching *_In with Mem_ReadData; for a store, load it with 0.
- RESP: lasts exactly one cycle, then IDLE. Requests are not sampled in RESP, so a request still high from the just-acked core is not re-issued.
- Latency: request high at edge N -> Mem strobe from N+1. Mem_Ack at edge M -> *_Ack high during cycle M+1. Minimum turnaround is 3 cycles for a zero-wait memory.
- Back-to-back: a request held continuously is re-granted no earlier than the cycle after RESP.
- Watchdog:
  - Counter clears on entering BUSY_x and increments each cycle in BUSY_x without Mem_Ack.
  - When it reaches TIMEOUT: drop strobes, enter RESP, pulse *_Ack and Bus_Error together; the read path returns ERR_DATA.
  - Mem_Ack on the same edge as the timeout takes precedence (normal completion, no Bus_Error).
- Mem_Ack outside BUSY_x is ignored.
- *_In holds its last value between acks.
- Only one *_Ack is ever high in a cycle.

Test Plan:
- Single fetch: InstMem_Read=1, address 0x3FF8, memory acks 1 cycle after the strobe with 0x20130003 -> Mem_Address=0x3FF8, Mem_Read high 2 cycles, InstMem_Ack one pulse with InstMem_In=0x20130003, DataMem_Ack stays 0.
- Store: DataMem_Write=4'b0011, DataMem_Read=1, address 0x10, DataMem_Out=0xCAFE1234 -> Mem_Write=0011, Mem_Read=0, Mem_WriteData=0xCAFE1234; DataMem_Ack pulses, DataMem_In=0.
- Contention: both requests held continuously after reset, zero-wait memory -> grant order D,I,D,I; each ack separated by ≥3 cycles; no duplicate transaction per ack.
- Timeout with TIMEOUT=4, no Mem_Ack on a load -> Mem_Read drops after 4 BUSY cycles; DataMem_Ack and Bus_Error pulse together; DataMem_In=0xDEADBEEF.
- Race: Mem_Ack arrives exactly on the timeout edge -> normal data returned, Bus_Error=0.
- Reset during BUSY_I: reset=1 for one edge -> all outputs 0 next cycle, no InstMem_Ack; after release with both requests pending, data is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side signals of mem_port_arbiter.
// master is the arbiter's view; slave is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic [ADDR_W-1:0] InstMem_Address;
  logic              InstMem_Read;
  logic [31:0]       InstMem_In;
  logic              InstMem_Ack;

  logic [ADDR_W-1:0] DataMem_Address;
  logic              DataMem_Read;
  logic [3:0]        DataMem_Write;
  logic [31:0]       DataMem_Out;
  logic [31:0]       DataMem_In;
  logic              DataMem_Ack;

  logic [ADDR_W-1:0] Mem_Address;
  logic              Mem_Read;
  logic [3:0]        Mem_Write;
  logic [31:0]       Mem_WriteData;
  logic [31:0]       Mem_ReadData;
  logic              Mem_Ack;

  logic              Bus_Error;

  modport master (
    input  InstMem_Address, InstMem_Read,
    output InstMem_In, InstMem_Ack,
    input  DataMem_Address, DataMem_Read, DataMem_Write, DataMem_Out,
    output DataMem_In, DataMem_Ack,
    output Mem_Address, Mem_Read, Mem_Write, Mem_WriteData,
    input  Mem_ReadData, Mem_Ack,
    output Bus_Error
  );

  modport slave (
    output InstMem_Address, InstMem_Read,
    input  InstMem_In, InstMem_Ack,
    output DataMem_Address, DataMem_Read, DataMem_Write, DataMem_Out,
    input  DataMem_In, DataMem_Ack,
    input  Mem_Address, Mem_Read, Mem_Write, Mem_WriteData,
    output Mem_ReadData, Mem_Ack,
    input  Bus_Error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access with
// alternating priority on contention and a no-ack watchdog.
module mem_port_arbiter #(
  parameter int          ADDR_W   = 30,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic           clock,
  input logic           reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              last_d;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              i_ack, d_ack, berr;
  logic [31:0]       i_in, d_in;

  logic i_req, d_req, grant_d, busy, timeout;

  assign i_req   = bus.InstMem_Read;
  assign d_req   = bus.DataMem_Read | (bus.DataMem_Write != 4'b0);
  // Fair tie-break: on contention the side that did not win last time goes.
  assign grant_d = d_req & (~i_req | ~last_d);
  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign timeout = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last_d  <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      berr    <= 1'b0;
      i_in    <= '0;
      d_in    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      berr  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            cnt    <= '0;
            last_d <= grant_d;
            if (grant_d) begin
              state   <= BUSY_D;
              addr_q  <= bus.DataMem_Address;
              be_q    <= bus.DataMem_Write;
              wdata_q <= bus.DataMem_Out;
            end else begin
              state  <= BUSY_I;
              addr_q <= bus.InstMem_Address;
              be_q   <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // A real ack on the timeout edge wins over the watchdog.
          if (bus.Mem_Ack || timeout) begin
            state <= RESP;
            berr  <= ~bus.Mem_Ack;
            if (state == BUSY_I) begin
              i_ack <= 1'b1;
              i_in  <= bus.Mem_Ack ? bus.Mem_ReadData : ERR_DATA;
            end else begin
              d_ack <= 1'b1;
              d_in  <= (be_q != 4'b0) ? 32'h0 :
                       (bus.Mem_Ack ? bus.Mem_ReadData : ERR_DATA);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Mem_Address   = addr_q;
  assign bus.Mem_Read      = (state == BUSY_I) || ((state == BUSY_D) && (be_q == 4'b0));
  assign bus.Mem_Write     = (state == BUSY_D) ? be_q : 4'b0;
  assign bus.Mem_WriteData = wdata_q;
  assign bus.InstMem_Ack   = i_ack;
  assign bus.InstMem_In    = i_in;
  assign bus.DataMem_Ack   = d_ack;
  assign bus.DataMem_In    = d_in;
  assign bus.Bus_Error     = berr;

  logic unused_busy;
  assign unused_busy = busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter against a transaction-level
// model that predicts grant order, strobe windows, ack timing and returned data.
module tb_mem_port_arbiter;
  localparam int          AW   = 30;
  localparam int          TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // requester side
  bit ip = 0, dp = 0;
  logic [AW-1:0] ia = '0, da = '0;
  logic [3:0]    dbe = '0;
  logic          dread = 1'b0;
  logic [31:0]   dwd = '0;

  // model of the outstanding transaction
  bit busy = 0, who_d = 0, last_d = 0, err = 0, rst_now = 0;
  int t0 = 0, dur = 0, lat = 0, elig = 0;
  logic [AW-1:0] x_addr = '0;
  logic [3:0]    x_be = '0;
  logic          x_rd = 1'b0;
  logic [31:0]   x_wd = '0, x_rdata = '0, x_iin = '0, x_din = '0;

  int lat_fix = -1;
  bit rd_fix_en = 0;
  logic [31:0] rd_fix = '0;
  int order[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_core();
    bus.InstMem_Read    = ip;
    bus.InstMem_Address = ia;
    bus.DataMem_Read    = dp ? dread : 1'b0;
    bus.DataMem_Write   = dp ? dbe : 4'b0;
    bus.DataMem_Address = da;
    bus.DataMem_Out     = dwd;
  endtask

  task automatic new_i(input logic [AW-1:0] a);
    ip = 1; ia = a;
  endtask

  task automatic new_d(input logic [AW-1:0] a, input logic [3:0] be, input logic rd,
                       input logic [31:0] wd);
    dp = 1; da = a; dbe = be; dread = rd; dwd = wd;
  endtask

  task automatic new_d_rand();
    if ($urandom_range(0, 1) == 0)
      new_d(AW'($urandom), 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom);
    else
      new_d(AW'($urandom), 4'h0, 1'b1, $urandom);
  endtask

  task automatic cycle_step();
    bit strobe, ack_now;
    @(posedge clock);
    cyc++;
    if (reset) begin
      busy = 0; last_d = 0; x_iin = '0; x_din = '0; elig = cyc + 1; rst_now = 1;
    end else begin
      rst_now = 0;
      if (!busy && cyc >= elig && (ip || dp)) begin
        who_d  = dp && (!ip || !last_d);
        last_d = who_d;
        busy   = 1;
        t0     = cyc;
        lat    = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 5);
        err    = (TO != 0) && (lat + 1 > TO);
        dur    = err ? TO : lat + 1;
        if (who_d) begin
          x_addr = da; x_be = dbe; x_rd = (dbe == 4'h0); x_wd = dwd;
        end else begin
          x_addr = ia; x_be = 4'h0; x_rd = 1'b1;
        end
      end
    end

    @(negedge clock);
    strobe  = busy && (cyc < t0 + dur);
    ack_now = busy && (cyc == t0 + dur);
    if (ack_now) begin
      if (who_d) x_din = (x_be != 4'h0) ? 32'h0 : (err ? ERRD : x_rdata);
      else       x_iin = err ? ERRD : x_rdata;
    end

    chk("mem_read",  64'(bus.Mem_Read),  64'(strobe && x_rd));
    chk("mem_write", 64'(bus.Mem_Write), 64'(strobe ? x_be : 4'h0));
    if (strobe) begin
      chk("mem_addr", 64'(bus.Mem_Address), 64'(x_addr));
      if (x_be != 4'h0) chk("mem_wdata", 64'(bus.Mem_WriteData), 64'(x_wd));
    end
    if (rst_now) begin
      chk("rst_addr",  64'(bus.Mem_Address),   64'(0));
      chk("rst_wdata", 64'(bus.Mem_WriteData), 64'(0));
    end
    chk("inst_ack",  64'(bus.InstMem_Ack), 64'(ack_now && !who_d));
    chk("data_ack",  64'(bus.DataMem_Ack), 64'(ack_now && who_d));
    chk("bus_error", 64'(bus.Bus_Error),   64'(ack_now && err));
    chk("inst_in",   64'(bus.InstMem_In),  64'(x_iin));
    chk("data_in",   64'(bus.DataMem_In),  64'(x_din));
    if (bus.DataMem_Ack) order.push_back(1);
    if (bus.InstMem_Ack) order.push_back(0);

    if (ack_now) begin
      busy = 0;
      elig = cyc + 2;
      if (who_d) dp = 0; else ip = 0;
    end

    // Memory side: real ack only at the chosen latency, noise acks otherwise.
    bus.Mem_ReadData = rd_fix_en ? rd_fix : $urandom;
    if (strobe) begin
      bus.Mem_Ack = (cyc == t0 + lat);
      if (cyc == t0 + lat) x_rdata = bus.Mem_ReadData;
    end else begin
      bus.Mem_Ack = ($urandom_range(0, 3) == 0);
    end
    drive_core();
  endtask

  task automatic run_idle(input int bound);
    int n = 0;
    while ((ip || dp || busy) && n < bound) begin
      cycle_step();
      n++;
    end
    chk("idle_wait", 64'(ip || dp || busy), 64'(0));
  endtask

  initial begin
    bus.Mem_Ack = 1'b0;
    bus.Mem_ReadData = '0;
    drive_core();
    reset = 1'b1;
    repeat (2) cycle_step();
    reset = 1'b0;
    cycle_step();

    // single fetch
    lat_fix = 1; rd_fix_en = 1; rd_fix = 32'h20130003;
    new_i(AW'(32'h3FF8)); drive_core();
    run_idle(50);
    chk("fetch_data", 64'(bus.InstMem_In), 64'(32'h20130003));

    // store with DataMem_Read also set
    lat_fix = 0;
    new_d(AW'(32'h10), 4'b0011, 1'b1, 32'hCAFE1234); drive_core();
    run_idle(50);
    chk("store_din", 64'(bus.DataMem_In), 64'(0));

    // load timeout
    lat_fix = 99;
    new_d(AW'(32'h20), 4'h0, 1'b1, 32'h0); drive_core();
    run_idle(50);
    chk("to_data", 64'(bus.DataMem_In), 64'(ERRD));

    // ack on the timeout edge
    lat_fix = TO - 1; rd_fix = 32'h13572468;
    new_d(AW'(32'h24), 4'h0, 1'b1, 32'h0); drive_core();
    run_idle(50);
    chk("race_data", 64'(bus.DataMem_In), 64'(32'h13572468));

    // contention from reset, zero-wait memory
    rd_fix_en = 0; lat_fix = 0;
    reset = 1'b1; cycle_step(); reset = 1'b0;
    order.delete();
    new_i(AW'($urandom)); new_d_rand(); drive_core();
    repeat (14) begin
      cycle_step();
      if (!ip) new_i(AW'($urandom));
      if (!dp) new_d_rand();
      drive_core();
    end
    run_idle(50);
    chk("order_len", 64'(order.size() >= 4), 64'(1));
    chk("order0", 64'(order[0]), 64'(1));
    chk("order1", 64'(order[1]), 64'(0));
    chk("order2", 64'(order[2]), 64'(1));
    chk("order3", 64'(order[3]), 64'(0));

    // reset in the middle of a fetch
    lat_fix = 99;
    new_i(AW'(32'h100)); drive_core();
    repeat (3) cycle_step();
    reset = 1'b1; new_d(AW'(32'h200), 4'h0, 1'b1, 32'h0); drive_core();
    cycle_step();
    reset = 1'b0; lat_fix = 1; order.delete();
    run_idle(50);
    chk("rst_first", 64'(order[0]), 64'(1));

    // random traffic, random latency including timeouts
    lat_fix = -1;
    repeat (1500) begin
      cycle_step();
      if (!ip && $urandom_range(0, 2) == 0) new_i(AW'($urandom));
      if (!dp && $urandom_range(0, 2) == 0) new_d_rand();
      drive_core();
    end
    run_idle(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
